// File: rtl/fault_diagnoser.sv
// Assembles per-vector pass/fail results into an observed syndrome, then scans the
// fault dictionary and hands out every fault index whose entry matches exactly.
module fault_diagnoser #(
  parameter int TST_COUNT   = 370,
  parameter int FAULT_COUNT = 256,
  parameter int IDX_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 res_valid,
  input  logic                 res_fail,
  output logic                 dict_rd,
  output logic [IDX_W-1:0]     dict_addr,
  input  logic [TST_COUNT-1:0] dict_data,
  output logic                 busy,
  output logic                 match_valid,
  input  logic                 match_ready,
  output logic [IDX_W-1:0]     match_idx,
  output logic [IDX_W:0]       match_count,
  output logic                 zero_syn,
  output logic                 done
);

  // state   | meaning
  // IDLE    | waiting for start; syndrome and result counter held clear
  // COLLECT | shifting accepted results into the syndrome
  // RD      | dictionary read strobe for entry scanIdx
  // CMP     | dict_data for scanIdx compared against the syndrome
  // EMIT    | presenting a matching index until downstream accepts it
  // DONE    | one-cycle completion pulse

  localparam int CNT_W = (TST_COUNT > 1) ? $clog2(TST_COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_RES = CNT_W'(TST_COUNT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FAULT_COUNT - 1);
  localparam logic [IDX_W:0]   CNT_MAX  = (IDX_W + 1)'(FAULT_COUNT);

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    RD,
    CMP,
    EMIT,
    DONE
  } state_t;

  state_t               state;
  logic [TST_COUNT-1:0] syndrome;
  logic [CNT_W-1:0]     resCnt;
  logic [IDX_W-1:0]     scanIdx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      syndrome    <= '0;
      resCnt      <= '0;
      scanIdx     <= '0;
      dict_rd     <= 1'b0;
      dict_addr   <= '0;
      busy        <= 1'b0;
      match_valid <= 1'b0;
      match_idx   <= '0;
      match_count <= '0;
      zero_syn    <= 1'b0;
      done        <= 1'b0;
    end else begin
      dict_rd <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          syndrome <= '0;
          resCnt   <= '0;
          if (start) begin
            state       <= COLLECT;
            busy        <= 1'b1;
            match_count <= '0;
            zero_syn    <= 1'b0;
          end
        end

        COLLECT: begin
          if (res_valid) begin
            syndrome[resCnt] <= res_fail;
            if (resCnt == LAST_RES) begin
              state     <= RD;
              scanIdx   <= '0;
              dict_rd   <= 1'b1;
              dict_addr <= '0;
              // bits above resCnt are still clear, so only the incoming bit can add a one
              zero_syn  <= ~(|syndrome | res_fail);
            end else begin
              resCnt <= resCnt + 1'b1;
            end
          end
        end

        RD: state <= CMP;

        CMP: begin
          if (dict_data == syndrome) begin
            state       <= EMIT;
            match_valid <= 1'b1;
            match_idx   <= scanIdx;
          end else if (scanIdx == LAST_IDX) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state     <= RD;
            scanIdx   <= scanIdx + 1'b1;
            dict_rd   <= 1'b1;
            dict_addr <= scanIdx + 1'b1;
          end
        end

        EMIT: begin
          if (match_ready) begin
            match_valid <= 1'b0;
            if (match_count != CNT_MAX) begin
              match_count <= match_count + 1'b1;
            end
            if (scanIdx == LAST_IDX) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= RD;
              scanIdx   <= scanIdx + 1'b1;
              dict_rd   <= 1'b1;
              dict_addr <= scanIdx + 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          match_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fault_diagnoser.sv
// Bench for fault_diagnoser: per-cycle comparison against an expected output
// timeline derived from the dictionary, the syndrome and the chosen stall lengths.
module tb_fault_diagnoser;
  localparam int TC = 8;
  localparam int FC = 4;
  localparam int IW = 2;
  localparam int TL = 128;

  logic clk = 1'b0;
  logic rst, start, res_valid, res_fail, match_ready;
  logic dict_rd, busy, match_valid, zero_syn, done;
  logic [IW-1:0] dict_addr, match_idx;
  logic [TC-1:0] dict_data;
  logic [IW:0]   match_count;

  always #5 clk = ~clk;

  fault_diagnoser #(.TST_COUNT(TC), .FAULT_COUNT(FC), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .res_valid(res_valid), .res_fail(res_fail),
    .dict_rd(dict_rd), .dict_addr(dict_addr), .dict_data(dict_data), .busy(busy),
    .match_valid(match_valid), .match_ready(match_ready), .match_idx(match_idx),
    .match_count(match_count), .zero_syn(zero_syn), .done(done)
  );

  // dictionary memory with one cycle read latency; garbage when not read
  logic [TC-1:0] dict [FC];
  always @(posedge clk) dict_data <= dict_rd ? dict[dict_addr] : TC'($urandom);

  // expectations for the current cycle, written only by the driver
  logic expBusy, expRd, expValid, expDone, expZero, chkAddr, chkIdx;
  logic [IW-1:0] expAddr, expIdx;
  logic [IW:0]   expCnt;
  bit    chkEn = 1'b0;
  bit    litValid = 1'b0;
  string litName = "";
  int    litAct = 0, litExp = 0;

  // written only by the compare process
  int checks = 0, failures = 0, cyc = 0;
  int obsValidCycles = 0, doneSeen = 0;
  int obsMatches[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (chkEn) begin
      check("busy", 32'(busy), 32'(expBusy));
      check("dict_rd", 32'(dict_rd), 32'(expRd));
      check("match_valid", 32'(match_valid), 32'(expValid));
      check("done", 32'(done), 32'(expDone));
      check("match_count", 32'(match_count), 32'(expCnt));
      check("zero_syn", 32'(zero_syn), 32'(expZero));
      if (chkAddr) check("dict_addr", 32'(dict_addr), 32'(expAddr));
      if (chkIdx)  check("match_idx", 32'(match_idx), 32'(expIdx));
      if (match_valid === 1'b1) obsValidCycles++;
      if (match_valid === 1'b1 && match_ready === 1'b1) obsMatches.push_back(int'(match_idx));
      if (done === 1'b1) doneSeen++;
    end
    if (litValid) check(litName, litAct, litExp);
  end

  // expected timeline, indexed by cycles after the last accepted result
  bit tRd[TL], tValid[TL], tDone[TL], tRdyFixed[TL], tRdyVal[TL];
  int tAddr[TL], tIdx[TL], tCnt[TL];
  int tEnd, firstEmit, finalCnt;
  logic [IW:0] lastCnt;
  logic lastZero;

  task automatic buildTimeline(input logic [TC-1:0] syn, input int stallFirst, input int stallRest);
    int t, cnt, nm, s;
    for (int o = 0; o < TL; o++) begin
      tRd[o] = 0; tValid[o] = 0; tDone[o] = 0; tRdyFixed[o] = 0; tRdyVal[o] = 0;
      tAddr[o] = 0; tIdx[o] = 0; tCnt[o] = 0;
    end
    t = 1; cnt = 0; nm = 0; firstEmit = -1;
    for (int k = 0; k < FC; k++) begin
      tRd[t] = 1; tAddr[t] = k; tCnt[t] = cnt; tCnt[t+1] = cnt;
      if (dict[k] == syn) begin
        if (nm == 0) s = stallFirst;
        else s = (stallRest < 0) ? $urandom_range(0, 3) : stallRest;
        if (firstEmit < 0) firstEmit = t + 2;
        for (int e = 0; e <= s; e++) begin
          tValid[t+2+e] = 1; tIdx[t+2+e] = k; tCnt[t+2+e] = cnt;
          tRdyFixed[t+2+e] = 1; tRdyVal[t+2+e] = (e == s);
        end
        cnt = (cnt < FC) ? cnt + 1 : cnt;
        nm++;
        t = t + 3 + s;
      end else begin
        t = t + 2;
      end
    end
    tDone[t] = 1; tCnt[t] = cnt; tEnd = t; finalCnt = cnt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    start = 1'b0; res_valid = 1'($urandom); res_fail = 1'($urandom); match_ready = 1'($urandom);
  endtask

  task automatic setExp(input logic b, input logic r, input logic v, input logic d,
                        input logic [IW:0] c, input logic z);
    expBusy = b; expRd = r; expValid = v; expDone = d; expCnt = c; expZero = z;
    chkAddr = 1'b0; chkIdx = 1'b0;
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    litName = nm; litAct = act; litExp = exp; litValid = 1'b1;
    @(negedge clk);
    #1 litValid = 1'b0;
  endtask

  task automatic runDiag(input logic [TC-1:0] syn, input int gapPct, input int stallFirst,
                         input int stallRest, input bit abortAtEmit, input bit startNoise);
    int acc;
    logic z;
    buildTimeline(syn, stallFirst, stallRest);
    z = (syn == '0);
    step(); idleInputs(); setExp(0, 0, 0, 0, lastCnt, lastZero);
    step(); idleInputs(); start = 1'b1; setExp(0, 0, 0, 0, lastCnt, lastZero);
    acc = 0;
    while (acc < TC) begin
      step();
      start = startNoise ? 1'($urandom) : 1'b0;
      match_ready = 1'($urandom);
      setExp(1, 0, 0, 0, '0, 0);
      if ($urandom_range(0, 99) < gapPct) begin
        res_valid = 1'b0; res_fail = 1'($urandom);
      end else begin
        res_valid = 1'b1; res_fail = syn[acc]; acc++;
      end
    end
    for (int off = 1; off <= tEnd; off++) begin
      step();
      start = 1'($urandom); res_valid = 1'($urandom); res_fail = 1'($urandom);
      match_ready = tRdyFixed[off] ? tRdyVal[off] : 1'($urandom);
      setExp(1, tRd[off], tValid[off], tDone[off], (IW+1)'(tCnt[off]), z);
      chkAddr = tRd[off]; expAddr = IW'(tAddr[off]);
      chkIdx = tValid[off]; expIdx = IW'(tIdx[off]);
      if (abortAtEmit && off == firstEmit) begin
        rst = 1'b1; match_ready = 1'b0;
        step(); rst = 1'b0; idleInputs();
        setExp(0, 0, 0, 0, '0, 0);
        chkAddr = 1'b1; expAddr = '0; chkIdx = 1'b1; expIdx = '0;
        lastCnt = '0; lastZero = 1'b0;
        repeat (4) begin step(); idleInputs(); setExp(0, 0, 0, 0, '0, 0); end
        return;
      end
    end
    lastCnt = (IW+1)'(finalCnt); lastZero = z;
    step(); idleInputs(); setExp(0, 0, 0, 0, lastCnt, lastZero);
  endtask

  int mb, vb, db;
  function automatic int obsAt(input int i);
    return (obsMatches.size() > i) ? obsMatches[i] : -1;
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; res_valid = 1'b0; res_fail = 1'b0; match_ready = 1'b0;
    dict[0] = 8'h00; dict[1] = 8'hA5; dict[2] = 8'h3C; dict[3] = 8'hA5;
    lastCnt = '0; lastZero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    setExp(0, 0, 0, 0, '0, 0);
    chkAddr = 1'b1; expAddr = '0; chkIdx = 1'b1; expIdx = '0;
    chkEn = 1'b1;
    step(); rst = 1'b0; idleInputs(); setExp(0, 0, 0, 0, '0, 0);

    mb = obsMatches.size(); db = doneSeen;
    runDiag(8'hA5, 0, 0, 0, 0, 0);
    lit("a5_model_done_offset", tEnd, 11);
    lit("a5_num_matches", obsMatches.size() - mb, 2);
    lit("a5_first_idx", obsAt(mb), 1);
    lit("a5_second_idx", obsAt(mb + 1), 3);
    lit("a5_match_count", int'(match_count), 2);
    lit("a5_zero_syn", int'(zero_syn), 0);
    lit("a5_done_pulses", doneSeen - db, 1);

    mb = obsMatches.size(); vb = obsValidCycles;
    runDiag(8'h3C, 0, 5, 0, 0, 0);
    lit("3c_valid_cycles", obsValidCycles - vb, 6);
    lit("3c_num_matches", obsMatches.size() - mb, 1);
    lit("3c_idx", obsAt(mb), 2);
    lit("3c_match_count", int'(match_count), 1);

    mb = obsMatches.size();
    runDiag(8'h00, 0, 0, 0, 0, 0);
    lit("zero_zero_syn", int'(zero_syn), 1);
    lit("zero_idx", obsAt(mb), 0);
    lit("zero_match_count", int'(match_count), 1);

    vb = obsValidCycles; db = doneSeen;
    runDiag(8'hFF, 0, 0, 0, 0, 0);
    lit("ff_model_done_offset", tEnd, 9);
    lit("ff_valid_cycles", obsValidCycles - vb, 0);
    lit("ff_match_count", int'(match_count), 0);
    lit("ff_done_pulses", doneSeen - db, 1);

    mb = obsMatches.size();
    runDiag(8'hA5, 40, 0, 0, 0, 1);
    lit("gap_num_matches", obsMatches.size() - mb, 2);
    lit("gap_first_idx", obsAt(mb), 1);
    lit("gap_second_idx", obsAt(mb + 1), 3);
    lit("gap_match_count", int'(match_count), 2);

    db = doneSeen;
    runDiag(8'hA5, 0, 3, 0, 1, 0);
    lit("abort_done_pulses", doneSeen - db, 0);
    lit("abort_busy", int'(busy), 0);
    mb = obsMatches.size();
    runDiag(8'hA5, 0, 0, 0, 0, 0);
    lit("rerun_first_idx", obsAt(mb), 1);
    lit("rerun_second_idx", obsAt(mb + 1), 3);

    for (int r = 0; r < 25; r++) begin
      logic [TC-1:0] syn;
      syn = ($urandom_range(0, 3) == 0) ? '0 : TC'($urandom);
      for (int k = 0; k < FC; k++) dict[k] = ($urandom_range(0, 1) == 1) ? syn : TC'($urandom);
      runDiag(syn, $urandom_range(0, 50), $urandom_range(0, 4), -1,
              ($urandom_range(0, 5) == 0), 1'($urandom));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
